// File: rtl/rubik_wr_seq_pkg.sv
// ============================================================================
// Module  : rubik_wr_seq_pkg
// Brief   : Shared types and field offsets for the Rubik write sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rubik_wr_seq_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CMD      = 2'd1,
    DATA     = 2'd2,
    WAIT_ACK = 2'd3
  } state_e;

  // Write-command word fields: [10] last, [9:0] size = beats-1
  localparam int LAST_BIT = 10;
  localparam int SIZE_MSB = 9;
  localparam int SIZE_W   = SIZE_MSB + 1;

  // Header: size field sits right above the line address
  function automatic int hdr_size_lsb(input int addr_w);
    return addr_w;
  endfunction

  // Header: require_ack bit follows the 13-bit size field
  function automatic int hdr_ack_bit(input int addr_w);
    return addr_w + 13;
  endfunction

  // Packet type bit (1 = header, 0 = data) is the MSB of the request
  function automatic int type_bit(input int data_w);
    return data_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rubik_wr_skid.sv
// ============================================================================
// Module  : rubik_wr_skid
// Brief   : 2-entry valid/ready skid buffer with registered outputs. The
//           space indication depends only on internal state, so upstream
//           ready never combinationally depends on downstream ready.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rubik_wr_skid #(
  parameter int WIDTH = 257
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_pd,
  output logic             space,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_pd
);

  logic             head_vld;
  logic             tail_vld;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             pop;

  assign pop     = head_vld & out_rdy;
  assign space   = ~tail_vld;
  assign out_vld = head_vld;
  assign out_pd  = head;

  // Head entry drives the output; tail catches a push that arrives while the head is stalled
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      head_vld <= 1'b0;
      tail_vld <= 1'b0;
      head     <= '0;
      tail     <= '0;
    end else if (!head_vld) begin
      if (in_vld) begin
        head     <= in_pd;
        head_vld <= 1'b1;
      end
    end else if (!tail_vld) begin
      if (pop) begin
        head_vld <= in_vld;
        if (in_vld) head <= in_pd;
      end else if (in_vld) begin
        tail     <= in_pd;
        tail_vld <= 1'b1;
      end
    end else if (pop) begin
      // Full: no push can arrive because space is low
      head     <= tail;
      tail_vld <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rubik_wr_seq.sv
// ============================================================================
// Module  : rubik_wr_seq
// Brief   : Rubik write sequencer. Turns each write command into one DMA
//           header followed by size+1 data beats, advances the destination
//           line address per command and raises op_done once the DMA acks
//           the final command of the layer.
// Config  : NV_RUBIK_WR_SEQ_PERF_EN adds perf_stall_cnt (saturating count of
//           cycles where a request is valid but the DMA is not ready).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rubik_wr_seq
  import rubik_wr_seq_pkg::*;
#(
  parameter int DATA_W     = 256,
  parameter int ADDR_W     = 64,
  parameter int BEAT_BYTES = 32
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              wcmd_pvld,
  output logic              wcmd_prdy,
  input  logic [10:0]       wcmd_pd,
  input  logic              dp_pvld,
  output logic              dp_prdy,
  input  logic [DATA_W-1:0] dp_pd,
  output logic              dma_wr_req_pvld,
  input  logic              dma_wr_req_prdy,
  output logic [DATA_W:0]   dma_wr_req_pd,
  input  logic              dma_wr_rsp_complete,
  input  logic              reg_op_en,
  input  logic [ADDR_W-1:0] reg_dst_base,
  input  logic [ADDR_W-1:0] reg_line_stride,
  output logic              op_done
`ifdef NV_RUBIK_WR_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int SIZE_LSB = hdr_size_lsb(ADDR_W);
  localparam int ACK_BIT  = hdr_ack_bit(ADDR_W);
  localparam int TYPE_BIT = type_bit(DATA_W);

  // The header must fit inside one beat and the beat size must match the bus width
  if ((DATA_W < ADDR_W + 14) || (BEAT_BYTES * 8 != DATA_W)) begin : g_cfg_check
    $error("rubik_wr_seq: inconsistent DATA_W / ADDR_W / BEAT_BYTES");
  end

  state_e            state;
  state_e            state_nxt;
  logic              op_en_d;
  logic              start;
  logic [ADDR_W-1:0] line_addr;
  logic [SIZE_W-1:0] size_q;
  logic [SIZE_W-1:0] beat_cnt;
  logic              last_q;
  logic              rsp_flag;
  logic              ack_seen;
  logic              wcmd_hs;
  logic              dp_hs;
  logic              final_beat;
  logic              done_fire;
  logic              skid_space;
  logic              push;
  logic [DATA_W:0]   push_pd;

  assign start      = reg_op_en & ~op_en_d;
  assign wcmd_hs    = wcmd_pvld & wcmd_prdy;
  assign dp_hs      = dp_pvld & dp_prdy;
  assign final_beat = dp_hs & (beat_cnt == size_q);
  assign ack_seen   = rsp_flag | dma_wr_rsp_complete;
  // An ack captured early completes the layer on the same edge the final beat is taken
  assign done_fire  = ((state == WAIT_ACK) & ack_seen) |
                      ((state == DATA) & final_beat & last_q & ack_seen);

  // State register
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) state <= IDLE;
    else                  state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = CMD;
      CMD:      if (wcmd_hs) state_nxt = DATA;
      DATA: begin
        if (final_beat) begin
          if (!last_q)       state_nxt = CMD;
          else if (ack_seen) state_nxt = IDLE;
          else               state_nxt = WAIT_ACK;
        end
      end
      default:  if (ack_seen) state_nxt = IDLE;
    endcase
  end

  // Output logic: handshakes gated by buffer space, header/data packet build
  always_comb begin
    wcmd_prdy = 1'b0;
    dp_prdy   = 1'b0;
    push_pd   = '0;
    case (state)
      CMD:     wcmd_prdy = skid_space;
      DATA:    dp_prdy   = skid_space;
      default: ;
    endcase
    if (wcmd_hs) begin
      push_pd[TYPE_BIT]               = 1'b1;
      push_pd[ADDR_W-1:0]             = line_addr;
      push_pd[SIZE_LSB +: SIZE_W]     = wcmd_pd[SIZE_MSB:0];
      push_pd[ACK_BIT]                = wcmd_pd[LAST_BIT];
    end else begin
      push_pd[DATA_W-1:0]             = dp_pd;
    end
  end

  assign push = wcmd_hs | dp_hs;

  // Layer datapath: enable edge, line address, command fields, beat count, early-ack flag
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      op_en_d   <= 1'b0;
      line_addr <= '0;
      size_q    <= '0;
      last_q    <= 1'b0;
      beat_cnt  <= '0;
      rsp_flag  <= 1'b0;
      op_done   <= 1'b0;
    end else begin
      op_en_d <= reg_op_en;
      op_done <= done_fire;
      if ((state == IDLE) && start)
        line_addr <= reg_dst_base;
      else if ((state == DATA) && final_beat)
        line_addr <= line_addr + reg_line_stride;
      if (wcmd_hs) begin
        size_q   <= wcmd_pd[SIZE_MSB:0];
        last_q   <= wcmd_pd[LAST_BIT];
        beat_cnt <= '0;
      end else if (dp_hs) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if ((state == IDLE) || done_fire)
        rsp_flag <= 1'b0;
      else if (dma_wr_rsp_complete)
        rsp_flag <= 1'b1;
    end
  end

  rubik_wr_skid #(
    .WIDTH (DATA_W + 1)
  ) u_skid (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .in_vld          (push),
    .in_pd           (push_pd),
    .space           (skid_space),
    .out_vld         (dma_wr_req_pvld),
    .out_rdy         (dma_wr_req_prdy),
    .out_pd          (dma_wr_req_pd)
  );

`ifdef NV_RUBIK_WR_SEQ_PERF_EN
  // Saturating count of stalled request cycles, cleared at each layer start
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn)
      perf_stall_cnt <= '0;
    else if ((state == IDLE) && start)
      perf_stall_cnt <= '0;
    else if (dma_wr_req_pvld && !dma_wr_req_prdy && (perf_stall_cnt != 32'hFFFF_FFFF))
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rubik_wr_seq.sv
// ============================================================================
// Module  : tb_rubik_wr_seq
// Brief   : Directed self-checking bench for rubik_wr_seq.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rubik_wr_seq;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 64;
  typedef logic [DATA_W:0] pkt_t;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              wcmd_pvld;
  logic              wcmd_prdy;
  logic [10:0]       wcmd_pd;
  logic              dp_pvld;
  logic              dp_prdy;
  logic [DATA_W-1:0] dp_pd;
  logic              req_pvld;
  logic              req_prdy = 1'b1;
  logic [DATA_W:0]   req_pd;
  logic              rsp;
  logic              op_en;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] stride;
  logic              op_done;
`ifdef NV_RUBIK_WR_SEQ_PERF_EN
  logic [31:0]       perf;
`endif

  rubik_wr_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BEAT_BYTES(32)) dut (
    .nvdla_core_clk      (clk),
    .nvdla_core_rstn     (rstn),
    .wcmd_pvld           (wcmd_pvld),
    .wcmd_prdy           (wcmd_prdy),
    .wcmd_pd             (wcmd_pd),
    .dp_pvld             (dp_pvld),
    .dp_prdy             (dp_prdy),
    .dp_pd               (dp_pd),
    .dma_wr_req_pvld     (req_pvld),
    .dma_wr_req_prdy     (req_prdy),
    .dma_wr_req_pd       (req_pd),
    .dma_wr_rsp_complete (rsp),
    .reg_op_en           (op_en),
    .reg_dst_base        (base),
    .reg_line_stride     (stride),
    .op_done             (op_done)
`ifdef NV_RUBIK_WR_SEQ_PERF_EN
    ,
    .perf_stall_cnt      (perf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input pkt_t got, input pkt_t exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // DMA ready driver: 0 = always ready, 1 = random 50%, 2 = stalled
  int prdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (prdy_mode)
      1:       req_prdy = 1'($urandom_range(0, 1));
      2:       req_prdy = 1'b0;
      default: req_prdy = 1'b1;
    endcase
  end

  // Output monitor: capture accepted packets, check hold-while-stalled, count op_done
  pkt_t got_q[$];
  pkt_t exp_q[$];
  int   done_cnt    = 0;
  int   done_cyc    = -1;
  int   stall_model = 0;
  logic prev_stall  = 1'b0;
  pkt_t prev_pd     = '0;
  always @(negedge clk) begin
    if (rstn) begin
      if (prev_stall) begin
        check("pvld_hold", pkt_t'(req_pvld), pkt_t'(1));
        check("pd_hold", req_pd, prev_pd);
      end
      if (req_pvld && req_prdy) got_q.push_back(req_pd);
      if (req_pvld && !req_prdy) stall_model++;
      prev_stall = req_pvld && !req_prdy;
      prev_pd    = req_pd;
      if (op_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  function automatic pkt_t hdr(input logic [63:0] a, input logic [9:0] s, input logic l);
    pkt_t p = '0;
    p[256]   = 1'b1;
    p[63:0]  = a;
    p[73:64] = s;
    p[77]    = l;
    return p;
  endfunction

  function automatic logic [DATA_W-1:0] beat(input int v);
    logic [31:0] w = v;
    return {8{w ^ 32'h5A5A_0000}};
  endfunction

  function automatic pkt_t dpkt(input int v);
    return {1'b0, beat(v)};
  endfunction

  int last_hs_cyc = 0;
  int rsp_cyc     = 0;

  task automatic send_cmd(input logic l, input logic [9:0] s);
    int t = 0;
    wcmd_pvld = 1'b1;
    wcmd_pd   = {l, s};
    do begin @(negedge clk); t++; end while (!wcmd_prdy && t < 5000);
    if (!wcmd_prdy) check("cmd_timeout", pkt_t'(0), pkt_t'(1));
    @(posedge clk); #1;
    wcmd_pvld = 1'b0;
  endtask

  task automatic send_beats(input int n, input int v0);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      dp_pvld = 1'b1;
      dp_pd   = beat(v0 + i);
      do begin @(negedge clk); t++; end while (!dp_prdy && t < 5000);
      if (!dp_prdy) check("beat_timeout", pkt_t'(0), pkt_t'(1));
      @(posedge clk); #1;
      last_hs_cyc = cyc;
    end
    dp_pvld = 1'b0;
  endtask

  task automatic start_layer(input logic [63:0] b, input logic [63:0] s);
    base   = b;
    stride = s;
    op_en  = 1'b0;
    @(posedge clk); #1;
    op_en       = 1'b1;
    done_cnt    = 0;
    stall_model = 0;
    @(posedge clk); #1;
  endtask

  task automatic drain_and_compare(input string tag);
    int t = 0;
    while (got_q.size() < exp_q.size() && t < 5000) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    check({tag, "_count"}, pkt_t'(got_q.size()), pkt_t'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_rsp();
    rsp     = 1'b1;
    rsp_cyc = cyc;
    @(posedge clk); #1;
    rsp = 1'b0;
  endtask

  task automatic finish_layer(input string tag);
    pulse_rsp();
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_once"}, pkt_t'(done_cnt), pkt_t'(1));
    check({tag, "_done_lat"}, pkt_t'(done_cyc), pkt_t'(rsp_cyc + 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    wcmd_pvld = 1'b0; wcmd_pd = '0; dp_pvld = 1'b0; dp_pd = '0;
    rsp = 1'b0; op_en = 1'b0; base = '0; stride = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_wcmd_prdy", pkt_t'(wcmd_prdy), pkt_t'(0));
    check("rst_dp_prdy",   pkt_t'(dp_prdy),   pkt_t'(0));
    check("rst_pvld",      pkt_t'(req_pvld),  pkt_t'(0));
    check("rst_op_done",   pkt_t'(op_done),   pkt_t'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Layer 1: two commands, basic header/data/ack flow
    start_layer(64'h1000, 64'h100);
    exp_q.push_back(hdr(64'h1000, 10'd1, 1'b0));
    exp_q.push_back(dpkt(0));
    exp_q.push_back(dpkt(1));
    exp_q.push_back(hdr(64'h1100, 10'd0, 1'b1));
    exp_q.push_back(dpkt(2));
    fork
      begin send_cmd(1'b0, 10'd1); send_cmd(1'b1, 10'd0); end
      send_beats(3, 0);
    join
    drain_and_compare("l1_pkt");
    finish_layer("l1");
    // Enable still high after done: no new layer starts
    wcmd_pvld = 1'b1;
    wcmd_pd   = 11'h000;
    repeat (5) @(negedge clk);
    check("idle_hold", pkt_t'(wcmd_prdy), pkt_t'(0));
    @(posedge clk); #1;
    wcmd_pvld = 1'b0;

    // Layer 2: maximum size command, 1024 beats
    start_layer(64'h2000, 64'h40);
    exp_q.push_back(hdr(64'h2000, 10'h3FF, 1'b1));
    for (int i = 0; i < 1024; i++) exp_q.push_back(dpkt(100 + i));
    fork
      send_cmd(1'b1, 10'h3FF);
      send_beats(1024, 100);
    join
    begin
      int t = 0;
      while (got_q.size() == 0 && t < 100) begin @(negedge clk); t++; end
    end
    check("l2_size_field", pkt_t'(got_q.size() > 0 ? got_q[0][73:64] : 10'd0), pkt_t'(10'h3FF));
    drain_and_compare("l2_pkt");
    finish_layer("l2");

    // Layer 3: random DMA back-pressure
    prdy_mode = 1;
    start_layer(64'h3000, 64'h20);
    exp_q.push_back(hdr(64'h3000, 10'd5, 1'b0));
    for (int i = 0; i < 6; i++) exp_q.push_back(dpkt(300 + i));
    exp_q.push_back(hdr(64'h3020, 10'd0, 1'b0));
    exp_q.push_back(dpkt(306));
    exp_q.push_back(hdr(64'h3040, 10'd3, 1'b1));
    for (int i = 0; i < 4; i++) exp_q.push_back(dpkt(307 + i));
    fork
      begin send_cmd(1'b0, 10'd5); send_cmd(1'b0, 10'd0); send_cmd(1'b1, 10'd3); end
      send_beats(11, 300);
    join
    drain_and_compare("l3_pkt");
    prdy_mode = 0;
    @(posedge clk); #1;
    finish_layer("l3");

    // Layer 4: ack arrives before the final beat is accepted
    start_layer(64'h4000, 64'h10);
    exp_q.push_back(hdr(64'h4000, 10'd3, 1'b1));
    for (int i = 0; i < 4; i++) exp_q.push_back(dpkt(200 + i));
    fork
      send_cmd(1'b1, 10'd3);
      send_beats(3, 200);
    join
    pulse_rsp();
    send_beats(1, 203);
    repeat (3) @(posedge clk);
    #1;
    check("l4_done_once", pkt_t'(done_cnt), pkt_t'(1));
    check("l4_done_early", pkt_t'(done_cyc), pkt_t'(last_hs_cyc));
    drain_and_compare("l4_pkt");

    // Layer 5: line address wraps; enable dropped mid-layer
    start_layer(64'hFFFF_FFFF_FFFF_FF80, 64'h100);
    op_en = 1'b0;
    exp_q.push_back(hdr(64'hFFFF_FFFF_FFFF_FF80, 10'd0, 1'b0));
    exp_q.push_back(dpkt(500));
    exp_q.push_back(hdr(64'h0000_0000_0000_0080, 10'd0, 1'b1));
    exp_q.push_back(dpkt(501));
    fork
      begin send_cmd(1'b0, 10'd0); send_cmd(1'b1, 10'd0); end
      send_beats(2, 500);
    join
    drain_and_compare("l5_pkt");
    finish_layer("l5");

`ifdef NV_RUBIK_WR_SEQ_PERF_EN
    // Layer 6: stall counter
    prdy_mode = 2;
    @(posedge clk); #1;
    start_layer(64'h6000, 64'h10);
    check("perf_clear", pkt_t'(perf), pkt_t'(0));
    exp_q.push_back(hdr(64'h6000, 10'd0, 1'b1));
    exp_q.push_back(dpkt(600));
    fork
      send_cmd(1'b1, 10'd0);
      send_beats(1, 600);
    join
    begin
      int t = 0;
      while (stall_model < 10 && t < 100) begin @(negedge clk); t++; end
    end
    prdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    check("perf_10", pkt_t'(perf), pkt_t'(32'd10));
    drain_and_compare("l6_pkt");
    finish_layer("l6");
    start_layer(64'h7000, 64'h10);
    check("perf_clear2", pkt_t'(perf), pkt_t'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
